lbp_img_server: RTL and testbench
=================================

Name: lbp_img_server

Overview:
- Host-side responder for the LBP engine's gray-image read interface and LBP-result write interface.
- Loads a 128x128 8-bit gray image from a raster-order pixel stream into an internal gray memory, then raises gray_ready.
- Serves engine reads on gray_req/gray_addr and captures engine writes on lbp_valid/lbp_addr/lbp_data into an internal result memory.
- After the engine asserts finish, exposes the result memory through a registered read-back port.

Parameters:
ADDR_W, 14, pixel address width ({row[6:0], col[6:0]})
DATA_W, 8, pixel / LBP code width
NPIX, 16384, pixels per image (2**ADDR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, in DONE returns block to LOAD for a new image
load_valid  in  1  input pixel valid
load_data  in  DATA_W  input pixel, raster order, address 0 first
load_ready  out  1  block accepts a pixel this cycle
gray_ready  out  1  image resident, engine may start
gray_req  in  1  engine read request
gray_addr  in  ADDR_W  engine read address
gray_data  out  DATA_W  read data to engine
lbp_valid  in  1  engine result write strobe
lbp_addr  in  ADDR_W  result address
lbp_data  in  DATA_W  LBP code
finish  in  1  engine done
wr_count  out  ADDR_W  number of result writes accepted this image
res_ready  out  1  results available for read-back
res_addr  in  ADDR_W  read-back address
res_data  out  DATA_W  read-back data, 1-cycle latency

Behaviour:
- Memories: gray_mem[NPIX] and res_mem[NPIX], DATA_W each. Counter load_cnt is ADDR_W+1 bits.
- Reset (reset=0, asynchronous): state=LOAD, load_cnt=0, wr_count=0, load_ready=0, gray_ready=0, res_ready=0, res_data=0. Memory contents are not reset.
- State LOAD:
  - load_ready=1 on every cycle after the first clock edge following reset release (registered).
  - Accepted pixel (load_valid & load_ready): gray_mem[load_cnt]<=load_data, res_mem[load_cnt]<=0, load_cnt++. The zero write guarantees that border addresses the engine never writes read back as 0.
  - On acceptance with load_cnt==NPIX-1: load_ready<=0, gray_ready<=1, state->SERVE. load_valid stalls (low) are allowed with no limit.
- State SERVE:
  - gray_data is combinational: gray_data = gray_mem[gray_addr] when gray_req=1, else 0. It updates the same cycle gray_addr changes, so an address registered at edge k is sampled by the engine at edge k+1.
  - lbp_valid=1: res_mem[lbp_addr]<=lbp_data, wr_count++ (saturates at NPIX-1).
  - Repeated writes to the same address: last write wins, and each write is counted.
  - finish=1: gray_ready<=0, res_ready<=1, state->DONE. An lbp_valid in the same cycle as finish is still written and counted.
  - load_valid is ignored.
- State DONE:
  - res_data<=res_mem[res_addr] every cycle (1-cycle latency).
  - gray_req, lbp_valid and finish are ignored; gray_data=0.
  - start=1: res_ready<=0, load_cnt<=0, wr_count<=0, state->LOAD, with load_ready=1 from the next cycle.
- start is ignored in LOAD and SERVE.
- Reset mid-load or mid-serve aborts: the state returns to LOAD and a full image must be reloaded. Stale res_mem entries are cleared by the reload.
- Outside DONE, res_data holds its last value.

Test Plan:
- Reset, then stream 16384 pixels with value = addr[7:0] and no stalls -> load_ready high for exactly 16384 accepting cycles; gray_ready rises the cycle after pixel 16383; load_ready=0 afterwards.
- Stream with load_valid toggling 1,0,1,0 -> gray_ready rises after 16384 accepted pixels (about 32768 cycles); gray_mem[0x0081]=0x81 checked via a gray read.
- SERVE: gray_req=1, gray_addr=0x0102 -> gray_data=0x02 in the same cycle; gray_req=0 -> gray_data=0.
- Write lbp_addr=0x0081 data 0x5A, then the same address with 0xA5, then finish alongside lbp_valid at addr 0x3F7E data 0x11 -> wr_count=3, res_ready=1; read-back 0x0081 gives 0xA5 one cycle later, 0x3F7E gives 0x11, 0x0000 gives 0x00.
- Assert reset low at load_cnt=5000, release, reload the full image -> gray_ready only after 16384 new pixels; wr_count=0.
- In DONE, pulse start -> res_ready=0, load_ready=1 the next cycle; a second image loads; gray_ready re-asserts.

Source files
------------

// File: rtl/lbp_img_server_if.sv
// ============================================================================
// lbp_img_server_if : host-side bus bundle between the LBP engine and server
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lbp_img_server_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic [ADDR_W-1:0] wr_count;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;

  modport slave (
    input  start, load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_addr,
    output load_ready, gray_ready, gray_data, wr_count, res_ready, res_data
  );

  modport master (
    output start, load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_addr,
    input  load_ready, gray_ready, gray_data, wr_count, res_ready, res_data
  );
endinterface

`default_nettype wire

// File: rtl/lbp_img_server.sv
// ============================================================================
// lbp_img_server : loads a gray image, serves LBP engine reads/writes, and
//                  exposes the result memory for read-back after finish
// Revision: 1.0
// ============================================================================
`default_nettype none

module lbp_img_server #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int NPIX   = 2**ADDR_W
) (
  input  wire logic         clk,
  input  wire logic         reset,
  lbp_img_server_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LAST_PIX = (ADDR_W+1)'(NPIX-1);
  localparam logic [ADDR_W-1:0] WR_MAX   = ADDR_W'(NPIX-1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
  logic                load_ready_q, load_ready_d;
  logic                gray_ready_q, gray_ready_d;
  logic                res_ready_q, res_ready_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;

  logic [DATA_W-1:0]   gray_mem [NPIX];
  logic [DATA_W-1:0]   res_mem  [NPIX];

  logic                load_acc;
  logic                lbp_wr;

  assign load_acc = (state_q == ST_LOAD) && bus.load_valid && load_ready_q;
  assign lbp_wr   = (state_q == ST_SERVE) && bus.lbp_valid;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    wr_count_d   = wr_count_q;
    load_ready_d = load_ready_q;
    gray_ready_d = gray_ready_q;
    res_ready_d  = res_ready_q;
    res_data_d   = res_data_q;
    case (state_q)
      ST_LOAD: begin
        load_ready_d = 1'b1;
        if (load_acc) begin
          load_cnt_d = load_cnt_q + (ADDR_W+1)'(1);
          if (load_cnt_q == LAST_PIX) begin
            load_ready_d = 1'b0;
            gray_ready_d = 1'b1;
            state_d      = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (bus.lbp_valid && (wr_count_q != WR_MAX)) begin
          wr_count_d = wr_count_q + ADDR_W'(1);
        end
        if (bus.finish) begin
          gray_ready_d = 1'b0;
          res_ready_d  = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        res_data_d = res_mem[bus.res_addr];
        if (bus.start) begin
          res_ready_d  = 1'b0;
          load_cnt_d   = '0;
          wr_count_d   = '0;
          load_ready_d = 1'b1;
          state_d      = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      load_cnt_q   <= '0;
      wr_count_q   <= '0;
      load_ready_q <= 1'b0;
      gray_ready_q <= 1'b0;
      res_ready_q  <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      wr_count_q   <= wr_count_d;
      load_ready_q <= load_ready_d;
      gray_ready_q <= gray_ready_d;
      res_ready_q  <= res_ready_d;
      res_data_q   <= res_data_d;
    end
  end

  // Zeroing res_mem while loading keeps never-written border addresses at 0.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      gray_mem[load_cnt_q[ADDR_W-1:0]] <= bus.load_data;
      res_mem[load_cnt_q[ADDR_W-1:0]]  <= '0;
    end else if (lbp_wr) begin
      res_mem[bus.lbp_addr] <= bus.lbp_data;
    end
  end

  assign bus.gray_data  = ((state_q == ST_SERVE) && bus.gray_req) ? gray_mem[bus.gray_addr] : '0;
  assign bus.load_ready = load_ready_q;
  assign bus.gray_ready = gray_ready_q;
  assign bus.res_ready  = res_ready_q;
  assign bus.res_data   = res_data_q;
  assign bus.wr_count   = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_lbp_img_server.sv
// Scoreboard bench for lbp_img_server: random images and engine traffic are
// checked against an array-based model of gray/result memories.
`default_nettype none

module tb_lbp_img_server;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int NPIX   = 16384;

  logic clk;
  logic reset;

  lbp_img_server_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lbp_img_server #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] img      [NPIX];
  logic [7:0] ref_gray [NPIX];
  logic [7:0] ref_res  [NPIX];
  int         wr_model = 0;
  logic [7:0] last_res = 8'h00;

  logic [7:0]        gray_q [$];
  logic [7:0]        res_q  [$];
  logic [ADDR_W-1:0] wr_addrs [$];

  logic gray_chk  = 1'b0;
  logic res_rd    = 1'b0;
  logic res_rd_d1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT data against the scoreboard queues.
  always @(posedge clk) res_rd_d1 <= res_rd;

  always @(negedge clk) begin
    logic [7:0] e;
    if (gray_chk) begin
      if (gray_q.size() == 0) chk("gray_q_underflow", 32'd1, 32'd0);
      else begin
        e = gray_q.pop_front();
        chk("gray_data", {24'd0, bus.gray_data}, {24'd0, e});
      end
    end
    if (res_rd_d1) begin
      if (res_q.size() == 0) chk("res_q_underflow", 32'd1, 32'd0);
      else begin
        e = res_q.pop_front();
        chk("res_data", {24'd0, bus.res_data}, {24'd0, e});
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_img(input bit ramp);
    for (int i = 0; i < NPIX; i++) img[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic load_image(input bit toggle, input int abort_at, output int cnt, output int cyc, output int early);
    bit ph;
    bit acc;
    cnt = 0; cyc = 0; early = 0; ph = 1'b0;
    while (cnt < NPIX && cnt != abort_at && cyc < 40000) begin
      bus.load_valid = toggle ? ~ph : 1'b1;
      ph = ~ph;
      bus.load_data = img[cnt];
      @(negedge clk);
      if (bus.gray_ready) early++;
      acc = bus.load_valid && bus.load_ready;
      tick();
      if (acc) begin
        ref_gray[cnt] = img[cnt];
        ref_res[cnt]  = 8'h00;
        cnt++;
      end
      cyc++;
    end
    bus.load_valid = 1'b0;
    if (cyc >= 40000) chk("load_timeout", 32'd1, 32'd0);
  endtask

  task automatic serve_cycle(input bit rd, input logic [ADDR_W-1:0] raddr,
                             input bit wr, input logic [ADDR_W-1:0] waddr,
                             input logic [7:0] wdata, input bit fin);
    bus.gray_req  = rd;
    bus.gray_addr = raddr;
    gray_chk      = rd;
    if (rd) gray_q.push_back(ref_gray[raddr]);
    bus.lbp_valid = wr;
    bus.lbp_addr  = waddr;
    bus.lbp_data  = wdata;
    if (wr) begin
      ref_res[waddr] = wdata;
      if (wr_model != NPIX - 1) wr_model++;
    end
    bus.finish = fin;
    tick();
    bus.gray_req  = 1'b0;
    gray_chk      = 1'b0;
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b0;
  endtask

  task automatic rd_res(input logic [ADDR_W-1:0] addr);
    bus.res_addr = addr;
    res_rd = 1'b1;
    res_q.push_back(ref_res[addr]);
    last_res = ref_res[addr];
    tick();
    res_rd = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wr_model = 0;
    @(negedge clk);
    chk("start_res_ready", {31'd0, bus.res_ready}, 32'd0);
    chk("start_load_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("start_wr_count", {18'd0, bus.wr_count}, 32'd0);
    chk("res_data_hold", {24'd0, bus.res_data}, {24'd0, last_res});
    tick();
  endtask

  task automatic after_load(input string tag, input int cnt, input int cyc, input int early, input int exp_cyc);
    chk({tag, "_accepted"}, cnt, NPIX);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_early_gray_ready"}, early, 32'd0);
    @(negedge clk);
    chk({tag, "_gray_ready"}, {31'd0, bus.gray_ready}, 32'd1);
    chk({tag, "_load_ready_low"}, {31'd0, bus.load_ready}, 32'd0);
    chk({tag, "_wr_count"}, {18'd0, bus.wr_count}, 32'd0);
    tick();
  endtask

  initial begin
    int cnt, cyc, early;
    logic [ADDR_W-1:0] a;
    reset = 1'b0;
    bus.start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
    bus.gray_req = 1'b0; bus.gray_addr = '0; bus.lbp_valid = 1'b0;
    bus.lbp_addr = '0; bus.lbp_data = '0; bus.finish = 1'b0; bus.res_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
    chk("rst_gray_ready", {31'd0, bus.gray_ready}, 32'd0);
    chk("rst_res_ready", {31'd0, bus.res_ready}, 32'd0);
    chk("rst_wr_count", {18'd0, bus.wr_count}, 32'd0);
    chk("rst_res_data", {24'd0, bus.res_data}, 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("first_cycle_load_ready", {31'd0, bus.load_ready}, 32'd0);
    tick();

    // Image A: ramp, no stalls
    gen_img(1'b1);
    load_image(1'b0, -1, cnt, cyc, early);
    after_load("imgA", cnt, cyc, early, NPIX);
    serve_cycle(1'b1, 14'h0102, 1'b0, '0, 8'h00, 1'b0);
    serve_cycle(1'b1, 14'h0081, 1'b0, '0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++)
      serve_cycle(1'b1, 14'($urandom_range(0, NPIX-1)), 1'b0, '0, 8'h00, 1'b0);
    bus.gray_req = 1'b0; bus.gray_addr = 14'h0102;
    @(negedge clk);
    chk("gray_req_low", {24'd0, bus.gray_data}, 32'd0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("serve_start_ignored_gray", {31'd0, bus.gray_ready}, 32'd1);
    chk("serve_start_ignored_res", {31'd0, bus.res_ready}, 32'd0);
    tick();
    serve_cycle(1'b0, '0, 1'b1, 14'h0081, 8'h5A, 1'b0);
    serve_cycle(1'b0, '0, 1'b1, 14'h0081, 8'hA5, 1'b0);
    serve_cycle(1'b0, '0, 1'b1, 14'h3F7E, 8'h11, 1'b1);
    @(negedge clk);
    chk("finish_res_ready", {31'd0, bus.res_ready}, 32'd1);
    chk("finish_gray_ready", {31'd0, bus.gray_ready}, 32'd0);
    chk("finish_wr_count", {18'd0, bus.wr_count}, wr_model);
    tick();
    // Engine traffic must be ignored once done
    bus.gray_req = 1'b1; bus.gray_addr = 14'h0102;
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'h0081; bus.lbp_data = 8'hFF; bus.finish = 1'b1;
    @(negedge clk);
    chk("done_gray_data", {24'd0, bus.gray_data}, 32'd0);
    tick();
    bus.gray_req = 1'b0; bus.lbp_valid = 1'b0; bus.finish = 1'b0;
    @(negedge clk);
    chk("done_wr_count", {18'd0, bus.wr_count}, wr_model);
    tick();
    rd_res(14'h0081);
    rd_res(14'h3F7E);
    rd_res(14'h0000);
    for (int i = 0; i < 8; i++) rd_res(14'($urandom_range(0, NPIX-1)));
    tick();
    pulse_start();

    // Image B: random, valid toggling
    gen_img(1'b0);
    load_image(1'b1, -1, cnt, cyc, early);
    after_load("imgB", cnt, cyc, early, 2*NPIX - 1);
    for (int i = 0; i < 200; i++) begin
      a = 14'($urandom_range(0, NPIX-1));
      if ($urandom_range(0, 1) == 1) wr_addrs.push_back(a);
      serve_cycle(1'($urandom_range(0, 1)), 14'($urandom_range(0, NPIX-1)),
                  (wr_addrs.size() > 0 && wr_addrs[wr_addrs.size()-1] == a), a,
                  8'($urandom), (i == 199));
    end
    @(negedge clk);
    chk("imgB_res_ready", {31'd0, bus.res_ready}, 32'd1);
    chk("imgB_wr_count", {18'd0, bus.wr_count}, wr_model);
    tick();
    foreach (wr_addrs[i]) if (i < 40) rd_res(wr_addrs[i]);
    tick();
    pulse_start();

    // Image C: abort by reset mid-load, then full reload
    gen_img(1'b0);
    load_image(1'b0, 5000, cnt, cyc, early);
    chk("partial_accepted", cnt, 32'd5000);
    reset = 1'b0;
    wr_model = 0;
    last_res = 8'h00;
    @(negedge clk);
    chk("abort_load_ready", {31'd0, bus.load_ready}, 32'd0);
    chk("abort_gray_ready", {31'd0, bus.gray_ready}, 32'd0);
    chk("abort_res_data", {24'd0, bus.res_data}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    gen_img(1'b0);
    load_image(1'b0, -1, cnt, cyc, early);
    after_load("imgC", cnt, cyc, early, NPIX);
    for (int i = 0; i < 20; i++)
      serve_cycle(1'b1, 14'($urandom_range(0, NPIX-1)), 1'b0, '0, 8'h00, (i == 19));
    @(negedge clk);
    chk("imgC_res_ready", {31'd0, bus.res_ready}, 32'd1);
    chk("imgC_wr_count", {18'd0, bus.wr_count}, 32'd0);
    tick();
    foreach (wr_addrs[i]) if (i < 20) rd_res(wr_addrs[i]);
    tick();
    tick();

    chk("gray_q_empty", gray_q.size(), 32'd0);
    chk("res_q_empty", res_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
